// File: rtl/pgm_pkg.sv
// Shared widths and FSM encoding for the PGM8755 programming sequencer.
package pgm_pkg;

  localparam int ADDR_W  = 11;
  localparam int COUNT_W = 12;
  localparam int DLY_W   = 22;
  localparam int DEPTH   = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_SETUP   = 3'd3,
    ST_PULSE   = 3'd4,
    ST_HOLD    = 3'd5,
    ST_VERIFY  = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  function automatic logic is_busy(input state_t s);
    return s inside {ST_RD, ST_RD_WAIT, ST_SETUP, ST_PULSE, ST_HOLD, ST_VERIFY};
  endfunction

endpackage

// File: rtl/pgm_delay_timer.sv
// Loadable down-counter shared by all timed programming phases.
// Loading N-1 gives N cycles until expired while the phase is active.
module pgm_delay_timer
  import pgm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DLY_W-1:0] value,
  output logic             expired
);

  logic [DLY_W-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/pgm_sequencer.sv
// PGM8755 sequencer: loads host bytes into the 2048x8 buffer, then programs them
// into the 8755 one timed cycle per byte. Define PGM_VERIFY_EN for read-back verify.
module pgm_sequencer
  import pgm_pkg::*;
#(
  parameter int PULSE_CYCLES = 2500000,
  parameter int SETUP_CYCLES = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic               start,
  input  logic               abort,
  output logic               buf_dir,
  output logic [ADDR_W-1:0]  buf_addr,
  output logic [7:0]         buf_wdata,
  input  logic [7:0]         buf_rdata,
  output logic [ADDR_W-1:0]  ep_addr,
  output logic [7:0]         ep_data,
  output logic               ep_data_oe,
  output logic               ep_prog,
`ifdef PGM_VERIFY_EN
  input  logic [7:0]         ep_rdata,
  output logic               verify_err,
`endif
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] byte_count
);

  localparam logic [DLY_W-1:0] SETUP_LOAD = DLY_W'(SETUP_CYCLES - 1);
  localparam logic [DLY_W-1:0] PULSE_LOAD = DLY_W'(PULSE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  rd_ptr;
  logic               full, accept, last_byte, advance;
  logic               tmr_load, tmr_expired;
  logic [DLY_W-1:0]   tmr_value;

  pgm_delay_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  assign full      = (byte_count == COUNT_W'(DEPTH));
  assign rx_ready  = !rst && (state_q == ST_IDLE) && !full && !start;
  assign accept    = rx_valid && rx_ready;
  assign last_byte = ({1'b0, rd_ptr} == byte_count - 1'b1);
  assign busy      = is_busy(state_q);
  assign done      = (state_q == ST_DONE);

  // The buffer writes on every edge with buf_dir low, so only an accepted byte may drop it.
  assign buf_dir   = !accept;
  assign buf_addr  = (state_q == ST_IDLE) ? byte_count[ADDR_W-1:0] : rd_ptr;
  assign buf_wdata = accept ? rx_data : '0;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_value = SETUP_LOAD;
    if (abort && busy) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (start) state_d = (byte_count == '0) ? ST_DONE : ST_RD;
        ST_RD:      state_d = ST_RD_WAIT;
        ST_RD_WAIT: begin
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
        end
        ST_SETUP: if (tmr_expired) begin
          state_d   = ST_PULSE;
          tmr_load  = 1'b1;
          tmr_value = PULSE_LOAD;
        end
        ST_PULSE: if (tmr_expired) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
        end
`ifdef PGM_VERIFY_EN
        ST_HOLD: if (tmr_expired) begin
          state_d  = ST_VERIFY;
          tmr_load = 1'b1;
        end
        ST_VERIFY:  if (tmr_expired) state_d = last_byte ? ST_DONE : ST_RD;
`else
        ST_HOLD:    if (tmr_expired) state_d = last_byte ? ST_DONE : ST_RD;
`endif
        ST_DONE:    state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  assign advance = (state_d == ST_RD) && (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_ptr     <= '0;
      byte_count <= '0;
      ep_addr    <= '0;
      ep_data    <= '0;
      ep_prog    <= 1'b0;
      ep_data_oe <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE) rd_ptr <= '0;
      else if (advance)       rd_ptr <= rd_ptr + 1'b1;
      if (accept)                 byte_count <= byte_count + 1'b1;
      else if (state_q == ST_DONE) byte_count <= '0;
      if (state_q == ST_RD_WAIT) begin
        ep_addr <= rd_ptr;
        ep_data <= buf_rdata;
      end
      // Socket controls are decoded from the next state so they leave a flop glitch-free.
      ep_prog    <= (state_d == ST_PULSE);
      ep_data_oe <= state_d inside {ST_SETUP, ST_PULSE, ST_HOLD};
    end
  end

`ifdef PGM_VERIFY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      verify_err <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      verify_err <= 1'b0;
    end else if (state_q == ST_VERIFY && tmr_expired && !abort && ep_rdata != ep_data) begin
      verify_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pgm_sequencer.sv
// Randomized self-checking bench for pgm_sequencer against a queue-based
// reference of loaded bytes and the per-byte programming timeline.
module tb_pgm_sequencer;

  localparam int P = 20;
  localparam int S = 3;
`ifdef PGM_VERIFY_EN
  localparam int COST = 2 + 3*S + P;
  localparam int TAIL = 2*S;
`else
  localparam int COST = 2 + 2*S + P;
  localparam int TAIL = S;
`endif
  localparam int FIRST_RISE = 3 + S;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        buf_dir;
  logic [10:0] buf_addr;
  logic [7:0]  buf_wdata;
  logic [7:0]  buf_rdata;
  logic [10:0] ep_addr;
  logic [7:0]  ep_data;
  logic        ep_data_oe;
  logic        ep_prog;
  logic        busy;
  logic        done;
  logic [11:0] byte_count;
`ifdef PGM_VERIFY_EN
  logic [7:0]  ep_rdata;
  logic        verify_err;
  assign ep_rdata = (ep_addr == 11'd1) ? 8'hFF : ep_data;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] model_q[$];
  logic [7:0] ram [0:2047];

  pgm_sequencer #(.PULSE_CYCLES(P), .SETUP_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .start      (start),
    .abort      (abort),
    .buf_dir    (buf_dir),
    .buf_addr   (buf_addr),
    .buf_wdata  (buf_wdata),
    .buf_rdata  (buf_rdata),
    .ep_addr    (ep_addr),
    .ep_data    (ep_data),
    .ep_data_oe (ep_data_oe),
    .ep_prog    (ep_prog),
`ifdef PGM_VERIFY_EN
    .ep_rdata   (ep_rdata),
    .verify_err (verify_err),
`endif
    .busy       (busy),
    .done       (done),
    .byte_count (byte_count)
  );

  always #5 clk = ~clk;

  // External buffer RAM: write when buf_dir is low, registered read.
  always @(posedge clk) begin
    if (!buf_dir) ram[buf_addr] <= buf_wdata;
    buf_rdata <= ram[buf_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_rx_ready", rx_ready, 0);
    check("rst_buf_dir", buf_dir, 1);
    check("rst_buf_addr", buf_addr, 0);
    check("rst_buf_wdata", buf_wdata, 0);
    check("rst_ep_addr", ep_addr, 0);
    check("rst_ep_data", ep_data, 0);
    check("rst_ep_data_oe", ep_data_oe, 0);
    check("rst_ep_prog", ep_prog, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_byte_count", byte_count, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic exp_ready;
    repeat (gap) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid  = 1'b1;
    rx_data   = b;
    exp_ready = (model_q.size() < 2048);
    check("rx_ready", rx_ready, exp_ready);
    if (exp_ready) model_q.push_back(b);
  endtask

  task automatic end_load();
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = '0;
    check("byte_count_load", byte_count, model_q.size());
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom), $urandom_range(0, 2));
    end_load();
  endtask

  // Expected: byte k pulses at ep_addr k with model_q[k], rising k*COST after the first.
  task automatic run_program();
    int   n = model_q.size();
    int   budget = n * COST + 20;
    int   cyc = 0, rises = 0, dones = 0, done_cyc = -1, width = 0, oe_bad = 0;
    logic prev_prog = 1'b0;
    logic exp_err;
    @(negedge clk);
    start = 1'b1;
    while (cyc < budget && !(dones > 0 && cyc >= done_cyc + 3)) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc == 1) begin
        check("busy_rise", busy, n != 0);
`ifdef PGM_VERIFY_EN
        check("verify_err_clr", verify_err, 0);
`endif
      end
      if (ep_prog && !ep_data_oe) oe_bad++;
      if (ep_prog && !prev_prog) begin
        check("ep_addr", ep_addr, rises);
        if (rises < n) check("ep_data", ep_data, model_q[rises]);
        check("rise_cyc", cyc, FIRST_RISE + rises * COST);
`ifdef PGM_VERIFY_EN
        exp_err = (rises >= 2) && (model_q[1] != 8'hFF);
        check("verify_err_mid", verify_err, exp_err);
`endif
        rises++;
        width = 0;
      end
      if (ep_prog) width++;
      if (!ep_prog && prev_prog) check("pulse_width", width, P);
      if (done) begin
        if (dones == 0) done_cyc = cyc;
        dones++;
      end
      prev_prog = ep_prog;
    end
    check("pulses", rises, n);
    check("done_pulses", dones, 1);
    check("done_cyc", done_cyc, (n == 0) ? 1 : FIRST_RISE + (n - 1) * COST + P + TAIL);
    check("oe_during_prog", oe_bad, 0);
    check("byte_count_clr", byte_count, 0);
    check("busy_end", busy, 0);
`ifdef PGM_VERIFY_EN
    exp_err = (n >= 2) && (model_q[1] != 8'hFF);
    check("verify_err_end", verify_err, exp_err);
`endif
    model_q.delete();
  endtask

  task automatic wait_rises(input int target, output int seen);
    int   cyc = 0;
    logic prev = 1'b0;
    seen = 0;
    @(negedge clk);
    start = 1'b1;
    while (seen < target && cyc < (target + 1) * COST) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (ep_prog && !prev) seen++;
      prev = ep_prog;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int dones;

    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    #1 check("rx_ready_after_rst", rx_ready, 1);

    // Directed load and program.
    send_byte(8'h3E, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    end_load();
    run_program();

    // Random loads with random handshake gaps.
    for (int r = 0; r < 3; r++) begin
      load_random($urandom_range(1, 5));
      run_program();
    end

    // Start with an empty buffer.
    run_program();

    // Abort during the second pulse; the loaded bytes survive for a rerun.
    load_random(3);
    wait_rises(2, seen);
    check("abort_reach", seen, 2);
    check("prog_before_abort", ep_prog, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ep_prog", ep_prog, 0);
    check("abort_oe", ep_data_oe, 0);
    check("abort_busy", busy, 0);
    check("abort_byte_count", byte_count, 3);
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    run_program();

    // Asynchronous reset in the middle of a pulse.
    load_random(2);
    wait_rises(1, seen);
    check("rst_reach", seen, 1);
    repeat (5) @(negedge clk);
    check("prog_before_rst", ep_prog, 1);
    #1 rst = 1'b1;
    #1 check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    #1 check("rx_ready_after_rst2", rx_ready, 1);
    model_q.delete();

    // Overfill: 2049 bytes, the last must not land on address 0.
    send_byte(8'h5A, 0);
    for (int i = 1; i < 2048; i++) send_byte(8'($urandom), 0);
    send_byte(8'hA5, 0);
    end_load();
    check("full_rx_ready", rx_ready, 0);
    check("full_addr0_kept", ram[0], 8'h5A);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    @(negedge clk);
    check("final_byte_count", byte_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
